// File: rtl/operand_select_reg.sv
// operand_select_reg
// Registered N:1 operand select for the ID/EX boundary. One of NUM_IN packed
// inputs is chosen by a binary SELECT and captured with valid, stall (hold)
// and flush (bubble) control. An out-of-range SELECT loads ILLEGAL_VAL and,
// when the slot is valid, latches a sticky error flag.
module operand_select_reg #(
    parameter int                WIDTH       = 32,
    parameter int                NUM_IN      = 3,
    parameter int                SEL_W       = 2,
    parameter logic [WIDTH-1:0]  ILLEGAL_VAL = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NUM_IN*WIDTH-1:0] IN_BUS,
    input  logic [SEL_W-1:0]        SELECT,
    input  logic                    IN_VALID,
    input  logic                    STALL,
    input  logic                    FLUSH,
    output logic [WIDTH-1:0]        OUT,
    output logic                    OUT_VALID,
    output logic                    SEL_ERR
);

    // Parameter sanity: every input must be addressable by SELECT.
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("operand_select_reg: NUM_IN must be in 2..16");
    end
    if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
        $error("operand_select_reg: SEL_W too narrow for NUM_IN");
    end

    // True when SELECT does not name an existing input. Constant 0 when
    // NUM_IN fills the whole SELECT code space.
    function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
        return (int'(sel) >= NUM_IN);
    endfunction

    // Pure combinational decode; falls back to ILLEGAL_VAL so OUT is never X.
    function automatic logic [WIDTH-1:0] sel_word(
        input logic [NUM_IN*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]        sel
    );
        logic [WIDTH-1:0] word;
        word = ILLEGAL_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                word = bus[k*WIDTH +: WIDTH];
            end
        end
        return word;
    endfunction

    // Stage p0: combinational operand select and legality check
    logic [WIDTH-1:0] data_p0;
    logic             ill_p0;
    logic             vld_p0;

    assign data_p0 = sel_word(IN_BUS, SELECT);
    assign ill_p0  = sel_illegal(SELECT);
    assign vld_p0  = IN_VALID;

    // Stage p1: pipeline register
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;
    logic             err_p1;

    // Capture register with priority reset > flush > stall > load; the error
    // flag survives flush and is cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else if (FLUSH) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (!STALL) begin
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
            if (vld_p0 && ill_p0) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign OUT       = data_p1;
    assign OUT_VALID = vld_p1;
    assign SEL_ERR   = err_p1;

endmodule

// File: tb/tb_operand_select_reg.sv
// tb_operand_select_reg
// Directed steps followed by random traffic, each cycle checked against a
// behavioural model of the select register built from the operand table.
module tb_operand_select_reg;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [NUM_IN*WIDTH-1:0] IN_BUS;
    logic [SEL_W-1:0]        SELECT;
    logic                    IN_VALID;
    logic                    STALL;
    logic                    FLUSH;
    logic [WIDTH-1:0]        OUT;
    logic                    OUT_VALID;
    logic                    SEL_ERR;

    int total = 0;
    int bad   = 0;

    // Operand table; IN_BUS is packed from it.
    logic [WIDTH-1:0] ins [NUM_IN];

    // Model state
    logic [WIDTH-1:0] m_out;
    logic             m_vld;
    logic             m_err;

    operand_select_reg #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .ILLEGAL_VAL(32'h0)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IN_BUS   (IN_BUS),
        .SELECT   (SELECT),
        .IN_VALID (IN_VALID),
        .STALL    (STALL),
        .FLUSH    (FLUSH),
        .OUT      (OUT),
        .OUT_VALID(OUT_VALID),
        .SEL_ERR  (SEL_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack_bus();
        IN_BUS = {ins[2], ins[1], ins[0]};
    endtask

    task automatic drive(input logic rst, input logic vld, input int sel,
                         input logic stl, input logic fl);
        RESET    = rst;
        IN_VALID = vld;
        SELECT   = sel[SEL_W-1:0];
        STALL    = stl;
        FLUSH    = fl;
    endtask

    // Behavioural effect of one clock edge on the register.
    task automatic model_edge();
        int s;
        s = int'(SELECT);
        if (RESET) begin
            m_out = '0;
            m_vld = 1'b0;
            m_err = 1'b0;
        end else if (FLUSH) begin
            m_out = '0;
            m_vld = 1'b0;
        end else if (!STALL) begin
            m_out = (s < NUM_IN) ? ins[s] : 32'h0;
            m_vld = IN_VALID;
            if (IN_VALID && s >= NUM_IN) m_err = 1'b1;
        end
    endtask

    // Advance one cycle and check all outputs against the model.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        chk({tag, ".out"}, OUT, m_out);
        chk({tag, ".vld"}, {31'b0, OUT_VALID}, {31'b0, m_vld});
        chk({tag, ".err"}, {31'b0, SEL_ERR}, {31'b0, m_err});
    endtask

    initial begin
        m_out = '0;
        m_vld = 1'b0;
        m_err = 1'b0;
        ins[0] = 32'hAAAA0000;
        ins[1] = 32'hBBBB0001;
        ins[2] = 32'hCCCC0002;
        pack_bus();
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        #2;

        // 1. reset for two cycles
        step("rst0");
        step("rst1");
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("rst.out_const", OUT, 32'h0);

        // 2. legal selects, valid
        drive(1'b0, 1'b1, 0, 1'b0, 1'b0); step("sel0");
        chk("sel0.const", OUT, 32'hAAAA0000);
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0); step("sel1");
        chk("sel1.const", OUT, 32'hBBBB0001);
        drive(1'b0, 1'b1, 2, 1'b0, 1'b0); step("sel2");
        chk("sel2.const", OUT, 32'hCCCC0002);

        // 3. load then stall three cycles
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0); step("ld1");
        drive(1'b0, 1'b0, 2, 1'b1, 1'b0);
        step("stall0"); step("stall1"); step("stall2");
        chk("stall.const", OUT, 32'hBBBB0001);
        drive(1'b0, 1'b0, 2, 1'b0, 1'b0); step("unstall");
        chk("unstall.const", OUT, 32'hCCCC0002);
        chk("unstall.vld_const", {31'b0, OUT_VALID}, 32'h0);

        // 4. stall and flush together
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0); step("pre_fl");
        drive(1'b0, 1'b1, 2, 1'b1, 1'b1); step("stall_flush");
        chk("stall_flush.const", OUT, 32'h0);

        // 5. illegal select with valid, sticky through flush
        drive(1'b0, 1'b1, 3, 1'b0, 1'b0); step("ill_v");
        chk("ill_v.err_const", {31'b0, SEL_ERR}, 32'h1);
        drive(1'b0, 1'b1, 0, 1'b0, 1'b1); step("ill_flush");
        drive(1'b0, 1'b1, 2, 1'b0, 1'b0); step("ill_legal");
        chk("ill_legal.err_const", {31'b0, SEL_ERR}, 32'h1);
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0); step("ill_rst");
        chk("ill_rst.err_const", {31'b0, SEL_ERR}, 32'h0);

        // 6. illegal select without valid, and under stall
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0); step("pre6");
        drive(1'b0, 1'b0, 3, 1'b0, 1'b0); step("ill_nv");
        chk("ill_nv.err_const", {31'b0, SEL_ERR}, 32'h0);
        drive(1'b0, 1'b1, 2, 1'b0, 1'b0); step("pre6b");
        drive(1'b0, 1'b1, 3, 1'b1, 1'b0); step("ill_stall");
        chk("ill_stall.const", OUT, 32'hCCCC0002);

        // reset mid-stall
        drive(1'b1, 1'b1, 1, 1'b1, 1'b0); step("rst_stall");
        drive(1'b0, 1'b1, 1, 1'b0, 1'b0); step("after_rst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_IN; k++) ins[k] = $urandom;
            pack_bus();
            drive(($urandom_range(0, 31) == 0),
                  $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
